// File: rtl/dispatch_queue.sv
// dispatch_queue: in-order packet buffer between fetch and dispatch, released under ROB/RS/PR/SQ budgets.
// Optional macro DISPATCH_QUEUE_BYPASS_EN lets accepted lanes dispatch in the same cycle through an empty queue.
module dispatch_queue #(
  parameter int DEPTH   = 16,
  parameter int FETCH_W = 3,
  parameter int DIS_W   = 3,
  parameter int PKT_W   = 128,
  parameter int CNT_W   = $clog2(DEPTH + 1),
  parameter int BUD_W   = $clog2(DIS_W + 1)
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          squash,
  input  logic [FETCH_W-1:0]            in_valid,
  input  logic [FETCH_W-1:0][PKT_W-1:0] in_packet,
  input  logic [FETCH_W-1:0]            in_pred_taken,
  input  logic [FETCH_W-1:0]            in_is_store,
  input  logic [FETCH_W-1:0]            in_has_dest,
  output logic                          in_ready,
  input  logic [BUD_W-1:0]              rob_free,
  input  logic [BUD_W-1:0]              rs_free,
  input  logic [BUD_W-1:0]              pr_free,
  input  logic [BUD_W-1:0]              sq_free,
  output logic [DIS_W-1:0]              dis_valid,
  output logic [DIS_W-1:0][PKT_W-1:0]   dis_packet,
  output logic [DIS_W-1:0]              dis_is_store,
  output logic [DIS_W-1:0]              dis_has_dest,
  output logic [CNT_W-1:0]              dq_count,
  output logic [31:0]                   dq_stall_cycles
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic [31:0]      r_stall;
  logic [PKT_W-1:0] r_mem   [DEPTH];
  logic             r_store [DEPTH];
  logic             r_dest  [DEPTH];

  logic                          w_ready;
  logic                          w_bypass;
  int                            w_accCnt;
  int                            w_disCnt;
  int                            w_skip;
  logic [FETCH_W-1:0][PKT_W-1:0] w_accPkt;
  logic [FETCH_W-1:0]            w_accStore;
  logic [FETCH_W-1:0]            w_accDest;
  logic [DIS_W-1:0][PKT_W-1:0]   w_candPkt;
  logic [DIS_W-1:0]              w_candValid;
  logic [DIS_W-1:0]              w_candStore;
  logic [DIS_W-1:0]              w_candDest;

  assign w_ready         = (DEPTH - int'(r_count)) >= FETCH_W;
  assign in_ready        = w_ready;
  assign dq_count        = r_count;
  assign dq_stall_cycles = r_stall;

`ifdef DISPATCH_QUEUE_BYPASS_EN
  assign w_bypass = (r_count == '0) && !squash && w_ready;
`else
  assign w_bypass = 1'b0;
`endif

  // Compact accepted lanes oldest-first; everything younger than the first predicted-taken lane is dropped.
  always_comb begin : acceptLogic
    logic cut;
    cut        = 1'b0;
    w_accCnt   = 0;
    w_accPkt   = '0;
    w_accStore = '0;
    w_accDest  = '0;
    for (int l = FETCH_W - 1; l >= 0; l--) begin
      if (w_ready && !squash && in_valid[l] && !cut) begin
        w_accPkt[w_accCnt]   = in_packet[l];
        w_accStore[w_accCnt] = in_is_store[l];
        w_accDest[w_accCnt]  = in_has_dest[l];
        w_accCnt             = w_accCnt + 1;
      end
      if (in_valid[l] && in_pred_taken[l]) cut = 1'b1;
    end
  end

  always_comb begin : candidateLogic
    w_candValid = '0;
    w_candPkt   = '0;
    w_candStore = '0;
    w_candDest  = '0;
    for (int k = 0; k < DIS_W; k++) begin
      if (w_bypass) begin
        if (k < w_accCnt) begin
          w_candValid[k] = 1'b1;
          w_candPkt[k]   = w_accPkt[k];
          w_candStore[k] = w_accStore[k];
          w_candDest[k]  = w_accDest[k];
        end
      end else begin
        w_candValid[k] = k < int'(r_count);
        w_candPkt[k]   = r_mem[r_head + PTR_W'(k)];
        w_candStore[k] = r_store[r_head + PTR_W'(k)];
        w_candDest[k]  = r_dest[r_head + PTR_W'(k)];
      end
    end
  end

  // Release stops at the first candidate that would overrun any budget.
  always_comb begin : dispatchLogic
    int   dSum;
    int   sSum;
    logic stop;
    dSum         = 0;
    sSum         = 0;
    stop         = 1'b0;
    w_disCnt     = 0;
    dis_valid    = '0;
    dis_packet   = '0;
    dis_is_store = '0;
    dis_has_dest = '0;
    for (int k = 0; k < DIS_W; k++) begin
      dis_packet[DIS_W-1-k]   = w_candPkt[k];
      dis_is_store[DIS_W-1-k] = w_candStore[k];
      dis_has_dest[DIS_W-1-k] = w_candDest[k];
      dSum = dSum + int'(w_candDest[k]);
      sSum = sSum + int'(w_candStore[k]);
      if (!stop && !squash && w_candValid[k] &&
          (k + 1) <= int'(rob_free) && (k + 1) <= int'(rs_free) &&
          dSum <= int'(pr_free) && sSum <= int'(sq_free)) begin
        dis_valid[DIS_W-1-k] = 1'b1;
        w_disCnt             = w_disCnt + 1;
      end else begin
        stop = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_stall <= '0;
    end else if (squash) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_bypass) begin
        r_tail <= r_tail + PTR_W'(w_accCnt - w_disCnt);
      end else begin
        r_head <= r_head + PTR_W'(w_disCnt);
        r_tail <= r_tail + PTR_W'(w_accCnt);
      end
      r_count <= r_count + CNT_W'(w_accCnt) - CNT_W'(w_disCnt);
      if (r_count != '0 && w_disCnt == 0 && r_stall != '1) r_stall <= r_stall + 32'd1;
    end
  end

  // Lanes already consumed by bypass are skipped so the rest land contiguously at tail.
  assign w_skip = w_bypass ? w_disCnt : 0;

  always_ff @(posedge clock) begin
    for (int j = 0; j < FETCH_W; j++) begin
      if (j >= w_skip && j < w_accCnt) begin
        r_mem[r_tail + PTR_W'(j - w_skip)]   <= w_accPkt[j];
        r_store[r_tail + PTR_W'(j - w_skip)] <= w_accStore[j];
        r_dest[r_tail + PTR_W'(j - w_skip)]  <= w_accDest[j];
      end
    end
  end

endmodule

// File: tb/tb_dispatch_queue.sv
// tb_dispatch_queue: table vectors plus a packet scoreboard for dispatch_queue.
// Follows DISPATCH_QUEUE_BYPASS_EN when the build defines it.
module tb_dispatch_queue;
  localparam int DEPTH   = 16;
  localparam int FETCH_W = 3;
  localparam int DIS_W   = 3;
  localparam int PKT_W   = 128;
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int BUD_W   = $clog2(DIS_W + 1);

  logic                          clock = 1'b0;
  logic                          reset_n = 1'b0;
  logic                          squash = 1'b0;
  logic [FETCH_W-1:0]            in_valid = '0;
  logic [FETCH_W-1:0][PKT_W-1:0] in_packet = '0;
  logic [FETCH_W-1:0]            in_pred_taken = '0;
  logic [FETCH_W-1:0]            in_is_store = '0;
  logic [FETCH_W-1:0]            in_has_dest = '0;
  logic                          in_ready;
  logic [BUD_W-1:0]              rob_free = '0;
  logic [BUD_W-1:0]              rs_free = '0;
  logic [BUD_W-1:0]              pr_free = '0;
  logic [BUD_W-1:0]              sq_free = '0;
  logic [DIS_W-1:0]              dis_valid;
  logic [DIS_W-1:0][PKT_W-1:0]   dis_packet;
  logic [DIS_W-1:0]              dis_is_store;
  logic [DIS_W-1:0]              dis_has_dest;
  logic [CNT_W-1:0]              dq_count;
  logic [31:0]                   dq_stall_cycles;

  dispatch_queue #(.DEPTH(DEPTH), .FETCH_W(FETCH_W), .DIS_W(DIS_W), .PKT_W(PKT_W)) dut (
    .clock(clock), .reset_n(reset_n), .squash(squash),
    .in_valid(in_valid), .in_packet(in_packet), .in_pred_taken(in_pred_taken),
    .in_is_store(in_is_store), .in_has_dest(in_has_dest), .in_ready(in_ready),
    .rob_free(rob_free), .rs_free(rs_free), .pr_free(pr_free), .sq_free(sq_free),
    .dis_valid(dis_valid), .dis_packet(dis_packet), .dis_is_store(dis_is_store),
    .dis_has_dest(dis_has_dest), .dq_count(dq_count), .dq_stall_cycles(dq_stall_cycles)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [PKT_W-1:0] pkt;
    logic             st;
    logic             dst;
  } entry_t;

  typedef struct {
    logic [2:0] vld, tkn, st, dst;
    logic [1:0] rob, rs, pr, sqf;
    logic       sqsh;
    logic [2:0] expMask;
    int         expCount;
  } vec_t;

  entry_t      sbq[$];
  logic [31:0] expStall = '0;
  int          errors = 0;
  int          checks = 0;
  int          pktSeq = 1;

  task automatic compare(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Predicts this cycle's outputs from the scoreboard, compares, then advances the scoreboard past the edge.
  task automatic checkOutput();
    entry_t     acc[$];
    entry_t     cand[$];
    entry_t     e;
    logic       cut;
    logic       ready;
    logic       byp;
    int         nExp, dSum, sSum;
    logic [DIS_W-1:0] expMask;
    ready = (DEPTH - sbq.size()) >= FETCH_W;
    cut = 1'b0;
    if (ready && !squash) begin
      for (int l = FETCH_W - 1; l >= 0; l--) begin
        if (in_valid[l] && !cut) begin
          e.pkt = in_packet[l];
          e.st  = in_is_store[l];
          e.dst = in_has_dest[l];
          acc.push_back(e);
        end
        if (in_valid[l] && in_pred_taken[l]) cut = 1'b1;
      end
    end
    byp = 1'b0;
`ifdef DISPATCH_QUEUE_BYPASS_EN
    byp = (sbq.size() == 0) && !squash && ready;
`endif
    if (byp) cand = acc;
    else     cand = sbq;
    nExp = 0; dSum = 0; sSum = 0; expMask = '0;
    if (!squash) begin
      for (int k = 0; k < DIS_W && k < cand.size(); k++) begin
        dSum += int'(cand[k].dst);
        sSum += int'(cand[k].st);
        if (nExp == k && k + 1 <= int'(rob_free) && k + 1 <= int'(rs_free) &&
            dSum <= int'(pr_free) && sSum <= int'(sq_free)) begin
          nExp++;
          expMask[DIS_W-1-k] = 1'b1;
        end
      end
    end
    compare("in_ready", 128'(in_ready), 128'(ready));
    compare("dq_count", 128'(dq_count), 128'(sbq.size()));
    compare("dis_valid", 128'(dis_valid), 128'(expMask));
    compare("stall_cycles", 128'(dq_stall_cycles), 128'(expStall));
    for (int k = 0; k < nExp; k++) begin
      compare($sformatf("pkt_lane%0d", DIS_W - 1 - k), dis_packet[DIS_W-1-k], cand[k].pkt);
      compare($sformatf("meta_lane%0d", DIS_W - 1 - k),
              128'({dis_is_store[DIS_W-1-k], dis_has_dest[DIS_W-1-k]}), 128'({cand[k].st, cand[k].dst}));
    end
    if (squash) begin
      sbq.delete();
    end else begin
      if (sbq.size() > 0 && nExp == 0 && expStall != 32'hFFFF_FFFF) expStall++;
      if (byp) begin
        for (int j = nExp; j < acc.size(); j++) sbq.push_back(acc[j]);
      end else begin
        repeat (nExp) void'(sbq.pop_front());
        foreach (acc[j]) sbq.push_back(acc[j]);
      end
    end
  endtask

  task automatic applyStimulus(input logic [FETCH_W-1:0] vld, input logic [FETCH_W-1:0] tkn,
                               input logic [FETCH_W-1:0] st, input logic [FETCH_W-1:0] dst,
                               input logic [BUD_W-1:0] rob, input logic [BUD_W-1:0] rs,
                               input logic [BUD_W-1:0] pr, input logic [BUD_W-1:0] sqf,
                               input logic sqsh);
    @(negedge clock);
    in_valid = vld; in_pred_taken = tkn; in_is_store = st; in_has_dest = dst;
    rob_free = rob; rs_free = rs; pr_free = pr; sq_free = sqf; squash = sqsh;
    for (int l = 0; l < FETCH_W; l++) begin
      in_packet[l] = {$urandom, $urandom, $urandom, 32'(pktSeq)};
      pktSeq++;
    end
    #1 checkOutput();
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[16];
    vecs[0]  = '{3'b111, 3'b000, 3'b000, 3'b000, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 3'b000, 0};
    vecs[1]  = '{3'b000, 3'b000, 3'b000, 3'b000, 2'd3, 2'd3, 2'd3, 2'd3, 1'b0, 3'b111, 3};
    vecs[2]  = '{3'b111, 3'b010, 3'b000, 3'b000, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 3'b000, 0};
    vecs[3]  = '{3'b000, 3'b000, 3'b000, 3'b000, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 3'b000, 2};
    vecs[4]  = '{3'b111, 3'b000, 3'b000, 3'b111, 2'd3, 2'd3, 2'd3, 2'd3, 1'b0, 3'b110, 2};
    vecs[5]  = '{3'b000, 3'b000, 3'b000, 3'b000, 2'd3, 2'd3, 2'd1, 2'd3, 1'b0, 3'b100, 3};
    vecs[6]  = '{3'b000, 3'b000, 3'b000, 3'b000, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 3'b000, 2};
    vecs[7]  = '{3'b000, 3'b000, 3'b000, 3'b000, 2'd3, 2'd3, 2'd3, 2'd3, 1'b0, 3'b110, 2};
    vecs[8]  = '{3'b111, 3'b000, 3'b110, 3'b000, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 3'b000, 0};
    vecs[9]  = '{3'b000, 3'b000, 3'b000, 3'b000, 2'd3, 2'd3, 2'd3, 2'd1, 1'b0, 3'b100, 3};
    vecs[10] = '{3'b000, 3'b000, 3'b000, 3'b000, 2'd1, 2'd3, 2'd3, 2'd3, 1'b0, 3'b100, 2};
    vecs[11] = '{3'b000, 3'b000, 3'b000, 3'b000, 2'd3, 2'd2, 2'd3, 2'd3, 1'b0, 3'b100, 1};
    vecs[12] = '{3'b111, 3'b000, 3'b000, 3'b000, 2'd3, 2'd3, 2'd3, 2'd3, 1'b1, 3'b000, 0};
    vecs[13] = '{3'b111, 3'b000, 3'b000, 3'b000, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 3'b000, 0};
    vecs[14] = '{3'b111, 3'b000, 3'b000, 3'b000, 2'd3, 2'd3, 2'd3, 2'd3, 1'b1, 3'b000, 3};
    vecs[15] = '{3'b000, 3'b000, 3'b000, 3'b000, 2'd3, 2'd3, 2'd3, 2'd3, 1'b0, 3'b000, 0};

    // Reset state
    repeat (2) @(negedge clock);
    compare("reset_in_ready", 128'(in_ready), 128'(1));
    compare("reset_count", 128'(dq_count), 128'(0));
    compare("reset_dis_valid", 128'(dis_valid), 128'(0));
    compare("reset_stall", 128'(dq_stall_cycles), 128'(0));
    reset_n = 1'b1;

    $display("[TB] table vectors");
    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].vld, vecs[i].tkn, vecs[i].st, vecs[i].dst,
                    vecs[i].rob, vecs[i].rs, vecs[i].pr, vecs[i].sqf, vecs[i].sqsh);
      compare($sformatf("vec%0d_mask", i), 128'(dis_valid), 128'(vecs[i].expMask));
      compare($sformatf("vec%0d_count", i), 128'(dq_count), 128'(vecs[i].expCount));
    end

    $display("[TB] fill until not ready, then enqueue with dispatch");
    repeat (5) applyStimulus(3'b111, 3'b000, 3'b000, 3'b000, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    applyStimulus(3'b111, 3'b000, 3'b000, 3'b000, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    compare("full_in_ready", 128'(in_ready), 128'(0));
    compare("full_count", 128'(dq_count), 128'(15));
    applyStimulus(3'b000, 3'b000, 3'b000, 3'b000, 2'd3, 2'd3, 2'd3, 2'd3, 1'b0);
    compare("full_count_ignored_input", 128'(dq_count), 128'(15));
    applyStimulus(3'b111, 3'b000, 3'b000, 3'b000, 2'd3, 2'd3, 2'd3, 2'd3, 1'b0);
    compare("simul_count_before", 128'(dq_count), 128'(12));
    compare("simul_mask", 128'(dis_valid), 128'(3'b111));
    applyStimulus(3'b000, 3'b000, 3'b000, 3'b000, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    compare("simul_count_after", 128'(dq_count), 128'(12));
    repeat (5) applyStimulus(3'b000, 3'b000, 3'b000, 3'b000, 2'd3, 2'd3, 2'd3, 2'd3, 1'b0);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      logic [2:0] v;
      logic [2:0] t;
      case ($urandom_range(0, 3))
        0:       v = 3'b000;
        1:       v = 3'b100;
        2:       v = 3'b110;
        default: v = 3'b111;
      endcase
      t = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      applyStimulus(v, t, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                    BUD_W'($urandom_range(0, 3)), BUD_W'($urandom_range(1, 3)),
                    BUD_W'($urandom_range(0, 3)), BUD_W'($urandom_range(0, 3)),
                    ($urandom_range(0, 29) == 0));
    end
    repeat (6) applyStimulus(3'b000, 3'b000, 3'b000, 3'b000, 2'd3, 2'd3, 2'd3, 2'd3, 1'b0);

    $display("[TB] asynchronous reset mid-operation");
    applyStimulus(3'b111, 3'b000, 3'b000, 3'b000, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    applyStimulus(3'b110, 3'b000, 3'b000, 3'b000, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    applyStimulus(3'b000, 3'b000, 3'b000, 3'b000, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    compare("pre_reset_count", 128'(dq_count), 128'(5));
    rob_free = 2'd3; rs_free = 2'd3; pr_free = 2'd3; sq_free = 2'd3;
    #1 reset_n = 1'b0;
    #1;
    compare("async_reset_dis_valid", 128'(dis_valid), 128'(0));
    compare("async_reset_count", 128'(dq_count), 128'(0));
    compare("async_reset_in_ready", 128'(in_ready), 128'(1));
    compare("async_reset_stall", 128'(dq_stall_cycles), 128'(0));
    sbq.delete();
    expStall = '0;
    @(negedge clock);
    reset_n = 1'b1;

    $display("[TB] stall counter saturation");
    applyStimulus(3'b111, 3'b000, 3'b000, 3'b000, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    force dut.r_stall = 32'hFFFF_FFFE;
    #1 release dut.r_stall;
    expStall = 32'hFFFF_FFFE;
    repeat (3) applyStimulus(3'b000, 3'b000, 3'b000, 3'b000, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    compare("stall_saturated", 128'(dq_stall_cycles), 128'(32'hFFFF_FFFF));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
